// File: rtl/sig_mon_pkg.sv
// sig_mon_pkg: shared state encoding and default parameters for sig_stable_mon.
package sig_mon_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, TRACK = 2'd2} state_e;
  localparam int WIDTH_DEF    = 1;
  localparam int MIN_HOLD_DEF = 3;
  localparam int CNT_W_DEF    = 8;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter; clr restarts at inc (so clr+inc loads 1).
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);
  logic [CNT_W-1:0] q_q, q_d;
  always_comb q_d = clr ? CNT_W'(inc) : (inc && q_q != '1) ? q_q + 1'b1 : q_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end
  assign q = q_q;
endmodule

// File: rtl/sig_stable_mon.sv
// sig_stable_mon: registered stable/changed/edge flags for a sampled signal,
// with run-length tracking and minimum-hold violation counting.
module sig_stable_mon
  import sig_mon_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int MIN_HOLD = MIN_HOLD_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] sig,
  output logic             stable,
  output logic             changed,
  output logic             rose,
  output logic             fell,
  output logic [CNT_W-1:0] run_len,
  output logic             viol,
  output logic [CNT_W-1:0] viol_cnt,
  output logic [1:0]       state
);
  localparam logic [CNT_W-1:0] HOLD = CNT_W'(MIN_HOLD);
  state_e           state_q;
  logic [WIDTH-1:0] prev_q;
  logic             armed_q, stable_q, changed_q, rose_q, fell_q, viol_q;
  logic             trk, chg, viol_d, run_clr, run_inc;
  always_comb begin
    trk     = en && state_q != IDLE;
    chg     = trk && sig != prev_q;
    viol_d  = chg && armed_q && run_len < HOLD;
    run_clr = clr || !en || chg || state_q == IDLE;
    run_inc = en && !clr;
  end
  // armed_q stays low until the first change after PRIME, whose run start is unknown
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      prev_q    <= '0;
      armed_q   <= 1'b0;
      stable_q  <= 1'b0;
      changed_q <= 1'b0;
      rose_q    <= 1'b0;
      fell_q    <= 1'b0;
      viol_q    <= 1'b0;
    end else begin
      state_q   <= !en ? IDLE : state_q == IDLE ? PRIME : TRACK;
      prev_q    <= en ? sig : prev_q;
      armed_q   <= trk && (armed_q || chg);
      stable_q  <= trk && !chg;
      changed_q <= chg;
      rose_q    <= chg && sig[0] && !prev_q[0];
      fell_q    <= chg && !sig[0] && prev_q[0];
      viol_q    <= viol_d;
    end
  end
  sat_counter #(.CNT_W(CNT_W)) u_run (
    .clk(clk), .rst_n(rst_n), .inc(run_inc), .clr(run_clr), .q(run_len)
  );
  sat_counter #(.CNT_W(CNT_W)) u_viol (
    .clk(clk), .rst_n(rst_n), .inc(viol_d && !clr), .clr(clr), .q(viol_cnt)
  );
  assign stable  = stable_q;
  assign changed = changed_q;
  assign rose    = rose_q;
  assign fell    = fell_q;
  assign viol    = viol_q;
  assign state   = state_q;
endmodule

// File: tb/tb_sig_stable_mon.sv
// tb_sig_stable_mon: directed tests for sig_stable_mon (default and small-counter instances).
module tb_sig_stable_mon;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, clr = 1'b0;
  logic [0:0] sig = 1'b0;
  logic       a_stable, a_changed, a_rose, a_fell, a_viol;
  logic [7:0] a_run, a_vcnt;
  logic [1:0] a_state;
  logic       b_stable, b_changed, b_rose, b_fell, b_viol;
  logic [1:0] b_run, b_vcnt;
  logic [1:0] b_state;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  sig_stable_mon #(.WIDTH(1), .MIN_HOLD(3), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .sig(sig),
    .stable(a_stable), .changed(a_changed), .rose(a_rose), .fell(a_fell),
    .run_len(a_run), .viol(a_viol), .viol_cnt(a_vcnt), .state(a_state)
  );
  sig_stable_mon #(.WIDTH(1), .MIN_HOLD(2), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .sig(sig),
    .stable(b_stable), .changed(b_changed), .rose(b_rose), .fell(b_fell),
    .run_len(b_run), .viol(b_viol), .viol_cnt(b_vcnt), .state(b_state)
  );

  task automatic step(input logic s, input logic e, input logic c);
    @(negedge clk);
    sig = s; en = e; clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; sig = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({a_state, a_run, a_vcnt, a_stable, a_changed, a_rose, a_fell, a_viol} !== 23'd0) begin
      bad++; $display("FAIL reset.a got state=%0d run=%0d vcnt=%0d exp all 0", a_state, a_run, a_vcnt);
    end
    total++;
    if ({b_state, b_run, b_vcnt, b_viol} !== 7'd0) begin
      bad++; $display("FAIL reset.b got state=%0d run=%0d vcnt=%0d exp all 0", b_state, b_run, b_vcnt);
    end
  endtask

  task automatic test_clean();
    int sv[6] = '{0, 0, 0, 0, 1, 1};
    int st[6] = '{1, 2, 2, 2, 2, 2};
    int rl[6] = '{1, 2, 3, 4, 1, 2};
    int ro[6] = '{0, 0, 0, 0, 1, 0};
    int sb[6] = '{0, 1, 1, 1, 0, 1};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'(sv[i]), 1'b1, 1'b0);
      total++;
      if (a_state !== 2'(st[i])) begin bad++; $display("FAIL clean.state i=%0d got=%0d exp=%0d", i, a_state, st[i]); end
      total++;
      if (a_run !== 8'(rl[i])) begin bad++; $display("FAIL clean.run i=%0d got=%0d exp=%0d", i, a_run, rl[i]); end
      total++;
      if (a_rose !== 1'(ro[i]) || a_changed !== 1'(ro[i])) begin bad++; $display("FAIL clean.rose i=%0d got=%0b/%0b exp=%0d", i, a_rose, a_changed, ro[i]); end
      total++;
      if (a_stable !== 1'(sb[i]) || a_viol !== 1'b0 || a_fell !== 1'b0) begin bad++; $display("FAIL clean.stable i=%0d got=%0b viol=%0b fell=%0b exp=%0d", i, a_stable, a_viol, a_fell, sb[i]); end
    end
  endtask

  task automatic test_glitch();
    int sv[7] = '{0, 0, 1, 1, 1, 0, 1};
    int rl[7] = '{1, 2, 1, 2, 3, 1, 1};
    int vi[7] = '{0, 0, 0, 0, 0, 0, 1};
    int vc[7] = '{0, 0, 0, 0, 0, 0, 1};
    int fe[7] = '{0, 0, 0, 0, 0, 1, 0};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(1'(sv[i]), 1'b1, 1'b0);
      total++;
      if (a_run !== 8'(rl[i])) begin bad++; $display("FAIL glitch.run i=%0d got=%0d exp=%0d", i, a_run, rl[i]); end
      total++;
      if (a_viol !== 1'(vi[i]) || a_vcnt !== 8'(vc[i])) begin bad++; $display("FAIL glitch.viol i=%0d got=%0b/%0d exp=%0d/%0d", i, a_viol, a_vcnt, vi[i], vc[i]); end
      total++;
      if (a_fell !== 1'(fe[i])) begin bad++; $display("FAIL glitch.fell i=%0d got=%0b exp=%0d", i, a_fell, fe[i]); end
    end
  endtask

  task automatic test_saturate();
    int sv[9] = '{0, 0, 1, 0, 1, 0, 1, 0, 1};
    int vi[9] = '{0, 0, 0, 1, 1, 1, 1, 1, 1};
    int vc[9] = '{0, 0, 0, 1, 2, 3, 3, 3, 3};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(1'(sv[i]), 1'b1, 1'b0);
      total++;
      if (b_viol !== 1'(vi[i]) || b_vcnt !== 2'(vc[i])) begin bad++; $display("FAIL sat.vcnt i=%0d got=%0b/%0d exp=%0d/%0d", i, b_viol, b_vcnt, vi[i], vc[i]); end
    end
  endtask

  task automatic test_clr_viol();
    do_reset();
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    total++;
    if (a_viol !== 1'b1 || a_vcnt !== 8'd0 || a_run !== 8'd0) begin bad++; $display("FAIL clr.same got viol=%0b vcnt=%0d run=%0d exp 1/0/0", a_viol, a_vcnt, a_run); end
    step(1'b1, 1'b1, 1'b0);
    total++;
    if (a_viol !== 1'b1 || a_vcnt !== 8'd1) begin bad++; $display("FAIL clr.next got viol=%0b vcnt=%0d exp 1/1", a_viol, a_vcnt); end
  endtask

  task automatic test_en_drop();
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    total++;
    if (a_state !== 2'd0 || a_run !== 8'd0 || a_stable !== 1'b0) begin bad++; $display("FAIL endrop.idle got state=%0d run=%0d stable=%0b exp 0/0/0", a_state, a_run, a_stable); end
    step(1'b0, 1'b1, 1'b0);
    total++;
    if (a_state !== 2'd1 || a_run !== 8'd1) begin bad++; $display("FAIL endrop.prime got state=%0d run=%0d exp 1/1", a_state, a_run); end
    step(1'b1, 1'b1, 1'b0);
    total++;
    if (a_state !== 2'd2 || a_changed !== 1'b1 || a_viol !== 1'b0) begin bad++; $display("FAIL endrop.exempt got state=%0d chg=%0b viol=%0b exp 2/1/0", a_state, a_changed, a_viol); end
    step(1'b0, 1'b1, 1'b0);
    total++;
    if (a_viol !== 1'b1 || a_vcnt !== 8'd1) begin bad++; $display("FAIL endrop.rearm got viol=%0b vcnt=%0d exp 1/1", a_viol, a_vcnt); end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    total++;
    if (a_state !== 2'd2 || a_vcnt !== 8'd2) begin bad++; $display("FAIL areset.pre got state=%0d vcnt=%0d exp 2/2", a_state, a_vcnt); end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({a_state, a_run, a_vcnt, a_stable, a_changed, a_rose, a_fell, a_viol} !== 23'd0) begin
      bad++; $display("FAIL areset.now got state=%0d run=%0d vcnt=%0d viol=%0b exp all 0", a_state, a_run, a_vcnt, a_viol);
    end
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1; sig = 1'b1;
    #2;
    total++;
    if (a_state !== 2'd0 || a_run !== 8'd0) begin bad++; $display("FAIL areset.hold got state=%0d run=%0d exp 0/0", a_state, a_run); end
    @(posedge clk);
    #1;
    total++;
    if (a_state !== 2'd1 || a_run !== 8'd1) begin bad++; $display("FAIL areset.release got state=%0d run=%0d exp 1/1", a_state, a_run); end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_glitch();
    test_saturate();
    test_clr_viol();
    test_en_drop();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sig_stable_mon.md
SIG_STABLE_MON -- requirements
Module: sig_stable_mon

Interface
REQ-001 SHALL have parameter WIDTH, default 1, width of the monitored signal.
REQ-002 SHALL have parameter MIN_HOLD, default 3, minimum number of consecutive equal samples a value must hold before it may change; legal range 1 to 2**CNT_W-1.
REQ-003 SHALL have parameter CNT_W, default 8, width of the run and violation counters.
REQ-004 clk  input  1  single clock; all sampling on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 en  input  1  monitor enable; level-sensitive.
REQ-007 clr  input  1  synchronous clear of viol_cnt and run_len.
REQ-008 sig  input  WIDTH  monitored signal, sampled each rising clk edge.
REQ-009 stable  output  1  current sample equals previous sample ($stable equivalent).
REQ-010 changed  output  1  current sample differs from previous sample.
REQ-011 rose  output  1  bit 0 went 0->1; fell  output  1  bit 0 went 1->0.
REQ-012 run_len  output  CNT_W  consecutive samples holding the current value, saturating.
REQ-013 viol  output  1  one-cycle pulse: value changed after holding fewer than MIN_HOLD samples.
REQ-014 viol_cnt  output  CNT_W  saturating count of viol pulses.
REQ-015 state  output  2  FSM state, encoded as IDLE=0, PRIME=1, TRACK=2.

Function
REQ-016 All outputs SHALL be registered; values seen after edge k SHALL describe sample k against sample k-1.
REQ-017 FSM: IDLE SHALL go to PRIME on an edge with en=1; PRIME SHALL go to TRACK on the next edge with en=1; any edge with en=0 SHALL force IDLE.
REQ-018 IDLE: stable, changed, rose, fell, viol and run_len SHALL be 0; the stored previous sample is don't-care; viol_cnt SHALL hold.
REQ-019 PRIME edge: SHALL capture sig as the previous sample, set run_len=1, and drive stable/changed/rose/fell/viol to 0.
REQ-020 TRACK edge, sig equals previous: stable=1, changed=0, run_len increments, saturating at 2**CNT_W-1.
REQ-021 TRACK edge, sig differs: changed=1, stable=0, rose/fell from bit 0, run_len=1, previous sample updated.
REQ-022 On a TRACK change, viol SHALL pulse if the pre-change run_len < MIN_HOLD, except for the first change after PRIME, because the start of that run is unknown.
REQ-023 viol_cnt SHALL increment on each viol and saturate at 2**CNT_W-1 without wrapping.
REQ-024 clr=1 SHALL zero viol_cnt and run_len at that edge; if viol fires on the same edge, the viol pulse SHALL still appear and viol_cnt SHALL be 0.
REQ-025 en falling mid-run SHALL lose history; re-enable SHALL restart at PRIME with the first-change exemption reapplied.

Reset
REQ-026 rst_n=0 SHALL immediately force state=IDLE and all outputs, including viol_cnt, to 0, independent of clk.
REQ-027 Reset release SHALL take effect on the first rising clk edge after rst_n=1; no output SHALL change before that edge.

Structure
REQ-028 Package sig_mon_pkg SHALL hold the state enum (IDLE/PRIME/TRACK) and the default parameter constants.
REQ-029 One sub-module, sat_counter (parameter CNT_W; inputs inc and clr; saturating output), SHALL implement both run_len and viol_cnt.
REQ-030 The implementation SHALL be synthesizable, free of latches and of any assertion or system-task constructs.

Verification
REQ-031 Async reset: assert rst_n=0 at 37 ns while in TRACK with viol_cnt=2 -> all outputs 0 and state=IDLE at 37 ns, with no clk edge needed.
REQ-032 Clean change, MIN_HOLD=3, en=1, sig=0,0,0,0,1,1 -> PRIME, then run_len 2,3,4; on the fifth sample rose=1, run_len=1, viol=0.
REQ-033 Glitch after the exempt change: sig=0,0,1,1,1,0,1 -> at the edge of the final sample viol=1 (run_len was 1) and viol_cnt=1; the change at the sixth sample gives fell=1 and no viol.
REQ-034 Saturation, CNT_W=2, MIN_HOLD=2: 6 single-sample glitches after the exempt change -> viol_cnt sequence 1,2,3,3,3,3.
REQ-035 clr coincident with viol -> viol=1 on that edge, viol_cnt=0 after it; the next viol gives viol_cnt=1.
REQ-036 en low for 1 cycle mid-run, then high -> state IDLE, PRIME, TRACK; the first subsequent change gives no viol even if the run is 1 sample long.
